syncfifo_read_ctrl: RTL and testbench

- Read-side controller for the systolic sync FIFO. It pairs with the write-pointer stage and sits downstream of it.
- Consumes the write pointer `w_ptr` and produces the read pointer `r_ptr` back to the write side, which uses it for its full check.
- Issues reads to the FIFO storage array, which has a registered (1-cycle-latency) read port.
- Presents entries on a 2-entry output buffer with a val/rdy handshake, sustaining 1 entry/cycle.

---
 rtl/syncfifo_read_ctrl.sv | 81 ++++++++
 tb/tb_syncfifo_read_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/syncfifo_read_ctrl.sv
// Read-side controller for the systolic sync FIFO: issues storage reads and presents
// entries through a 2-entry val/rdy output buffer. Optional macro: SYNCFIFO_RD_COUNT_EN.
module syncfifo_read_ctrl #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned PTR_WIDTH  = $clog2(DEPTH) + 1,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 3)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PTR_WIDTH-1:0]  w_ptr,
    output logic [PTR_WIDTH-1:0]  r_ptr,
    output logic                  ren,
    output logic [PTR_WIDTH-2:0]  raddr,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  deq_val,
    input  logic                  deq_rdy,
    output logic [DATA_WIDTH-1:0] deq_msg,
    output logic                  empty
`ifdef SYNCFIFO_RD_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  count
`endif
);

    logic [DATA_WIDTH-1:0] slot [2];
    logic                  head;
    logic                  tail;
    logic [1:0]            bcnt;
    logic                  inflight;
    logic                  deq_fire;
    logic [2:0]            credit;

    assign empty    = (w_ptr == r_ptr);
    assign raddr    = r_ptr[PTR_WIDTH-2:0];
    assign deq_val  = (bcnt != 2'd0);
    assign deq_msg  = slot[head];
    assign deq_fire = deq_val & deq_rdy;

    // Buffer slots already claimed after this edge; a read needs a free one.
    assign credit = 3'(bcnt) + 3'(inflight) - 3'(deq_fire);
    assign ren    = ~empty & ~rst & (credit < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            inflight <= 1'b0;
            head     <= 1'b0;
            tail     <= 1'b0;
            bcnt     <= 2'd0;
            slot[0]  <= '0;
            slot[1]  <= '0;
        end else begin
            if (ren) begin
                r_ptr <= r_ptr + PTR_WIDTH'(1);
            end
            inflight <= ren;
            if (inflight) begin
                slot[tail] <= rdata;
                tail       <= ~tail;
            end
            if (deq_fire) begin
                head <= ~head;
            end
            // Simultaneous fill and drain leaves occupancy unchanged.
            if (inflight && !deq_fire) begin
                bcnt <= bcnt + 2'd1;
            end else if (!inflight && deq_fire) begin
                bcnt <= bcnt - 2'd1;
            end
        end
    end

`ifdef SYNCFIFO_RD_COUNT_EN
    logic [PTR_WIDTH-1:0] stored;

    assign stored = w_ptr - r_ptr;
    assign count  = rst ? '0 : CNT_WIDTH'(stored) + CNT_WIDTH'(inflight) + CNT_WIDTH'(bcnt);
`endif

endmodule

// File: tb/tb_syncfifo_read_ctrl.sv
// Directed bench for syncfifo_read_ctrl with a registered-read storage model and writer.
module tb_syncfifo_read_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 3;
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] w_ptr;
    logic [PW-1:0] r_ptr;
    logic          ren;
    logic [PW-2:0] raddr;
    logic [DW-1:0] rdata;
    logic          deq_val;
    logic          deq_rdy;
    logic [DW-1:0] deq_msg;
    logic          empty;
`ifdef SYNCFIFO_RD_COUNT_EN
    logic [CW-1:0] count;
`endif

    logic [DW-1:0] mem [DEPTH];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (ren) rdata <= mem[raddr];

    syncfifo_read_ctrl #(.DEPTH(DEPTH), .PTR_WIDTH(PW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk     (clk),
        .rst     (rst),
        .w_ptr   (w_ptr),
        .r_ptr   (r_ptr),
        .ren     (ren),
        .raddr   (raddr),
        .rdata   (rdata),
        .deq_val (deq_val),
        .deq_rdy (deq_rdy),
        .deq_msg (deq_msg),
        .empty   (empty)
`ifdef SYNCFIFO_RD_COUNT_EN
        ,
        .count   (count)
`endif
    );

    task automatic push(input logic [DW-1:0] d);
        mem[w_ptr[PW-2:0]] = d;
        w_ptr = w_ptr + PW'(1);
    endtask

    task automatic test_reset();
        rst = 1'b1; w_ptr = '0; deq_rdy = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        checks++; if (ren !== 1'b0) begin errors++; $display("FAIL rst_ren got %0h exp 0", ren); end
        checks++; if (deq_val !== 1'b0) begin errors++; $display("FAIL rst_val got %0h exp 0", deq_val); end
        checks++; if (deq_msg !== 32'h0) begin errors++; $display("FAIL rst_msg got %0h exp 0", deq_msg); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++; if (ren !== 1'b0) begin errors++; $display("FAIL idle_ren got %0h exp 0", ren); end
            checks++; if (deq_val !== 1'b0) begin errors++; $display("FAIL idle_val got %0h exp 0", deq_val); end
            checks++; if (r_ptr !== 3'd0) begin errors++; $display("FAIL idle_rptr got %0h exp 0", r_ptr); end
            checks++; if (empty !== 1'b1) begin errors++; $display("FAIL idle_empty got %0h exp 1", empty); end
        end
    endtask

    task automatic test_single();
        @(negedge clk); push(32'hA5); #1;
        checks++; if (ren !== 1'b1) begin errors++; $display("FAIL single_ren got %0h exp 1", ren); end
        checks++; if (raddr !== 2'd0) begin errors++; $display("FAIL single_raddr got %0h exp 0", raddr); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty0 got %0h exp 0", empty); end
        @(negedge clk); #1;
        checks++; if (deq_val !== 1'b0) begin errors++; $display("FAIL single_val1 got %0h exp 0", deq_val); end
        checks++; if (r_ptr !== 3'd1) begin errors++; $display("FAIL single_rptr got %0h exp 1", r_ptr); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty1 got %0h exp 1", empty); end
        checks++; if (ren !== 1'b0) begin errors++; $display("FAIL single_ren1 got %0h exp 0", ren); end
        @(negedge clk); #1;
        checks++; if (deq_val !== 1'b1) begin errors++; $display("FAIL single_val2 got %0h exp 1", deq_val); end
        checks++; if (deq_msg !== 32'hA5) begin errors++; $display("FAIL single_msg got %0h exp a5", deq_msg); end
        @(negedge clk); #1;
        checks++; if (deq_val !== 1'b0) begin errors++; $display("FAIL single_val3 got %0h exp 0", deq_val); end
    endtask

    task automatic test_stream();
        int sent = 0;
        bit saw_wrap = 1'b0;
        logic [PW-1:0] prev = r_ptr;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (prev == 3'd7 && r_ptr == 3'd0) saw_wrap = 1'b1;
            prev = r_ptr;
            if (sent < 8 && w_ptr != (r_ptr ^ 3'b100)) begin push(32'(32'h10 + sent)); sent++; end
            #1;
            checks++; if (r_ptr !== PW'(1 + ((i < 8) ? i : 8))) begin errors++; $display("FAIL stream_rptr cyc %0d got %0h exp %0h", i, r_ptr, PW'(1 + ((i < 8) ? i : 8))); end
            if (i < 8) begin
                checks++; if (ren !== 1'b1) begin errors++; $display("FAIL stream_ren cyc %0d got %0h exp 1", i, ren); end
            end
            if (i >= 2 && i < 10) begin
                checks++; if (deq_val !== 1'b1) begin errors++; $display("FAIL stream_val cyc %0d got %0h exp 1", i, deq_val); end
                checks++; if (deq_msg !== 32'(32'h10 + i - 2)) begin errors++; $display("FAIL stream_msg cyc %0d got %0h exp %0h", i, deq_msg, 32'(32'h10 + i - 2)); end
            end else begin
                checks++; if (deq_val !== 1'b0) begin errors++; $display("FAIL stream_idle cyc %0d got %0h exp 0", i, deq_val); end
            end
        end
        checks++; if (saw_wrap !== 1'b1) begin errors++; $display("FAIL stream_wrap got %0h exp 1", saw_wrap); end
    endtask

    task automatic test_backpressure();
        int got = 0;
        @(negedge clk); deq_rdy = 1'b0;
        for (int k = 0; k < 4; k++) push(32'(32'h20 + k));
        #1;
        checks++; if (ren !== 1'b1) begin errors++; $display("FAIL bp_full_ren got %0h exp 1", ren); end
        repeat (5) @(negedge clk);
        #1;
        checks++; if (r_ptr !== 3'd3) begin errors++; $display("FAIL bp_rptr got %0h exp 3", r_ptr); end
        checks++; if (ren !== 1'b0) begin errors++; $display("FAIL bp_ren got %0h exp 0", ren); end
        checks++; if (deq_val !== 1'b1) begin errors++; $display("FAIL bp_val got %0h exp 1", deq_val); end
        checks++; if (deq_msg !== 32'h20) begin errors++; $display("FAIL bp_msg got %0h exp 20", deq_msg); end
        deq_rdy = 1'b1; #1;
        checks++; if (ren !== 1'b1) begin errors++; $display("FAIL bp_rdy_ren got %0h exp 1", ren); end
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (deq_val) begin
                checks++; if (deq_msg !== 32'(32'h20 + got)) begin errors++; $display("FAIL bp_drain got %0h exp %0h", deq_msg, 32'(32'h20 + got)); end
                got++;
            end
            @(negedge clk); #1;
        end
        checks++; if (got != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", got); end
        checks++; if (r_ptr !== 3'd5) begin errors++; $display("FAIL bp_rptr_end got %0h exp 5", r_ptr); end
        checks++; if (deq_val !== 1'b0) begin errors++; $display("FAIL bp_val_end got %0h exp 0", deq_val); end
    endtask

    task automatic test_toggle();
        logic [DW-1:0] q[$];
        logic [DW-1:0] d;
        int written = 0;
        int deqd = 0;
        int reads = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            deq_rdy = (cyc % 2 == 0);
            if (cyc < 80 && $urandom_range(0, 2) != 0 && w_ptr != (r_ptr ^ 3'b100)) begin
                d = $urandom; push(d); q.push_back(d); written++;
            end
            #1;
            if (ren) reads++;
`ifdef SYNCFIFO_RD_COUNT_EN
            checks++; if (count !== CW'(written - deqd)) begin errors++; $display("FAIL tog_count cyc %0d got %0d exp %0d", cyc, count, written - deqd); end
`endif
            if (deq_val && deq_rdy) begin
                checks++;
                if (q.size() == 0) begin errors++; $display("FAIL tog_extra cyc %0d got %0h exp none", cyc, deq_msg); end
                else begin
                    if (deq_msg !== q[0]) begin errors++; $display("FAIL tog_order cyc %0d got %0h exp %0h", cyc, deq_msg, q[0]); end
                    void'(q.pop_front());
                end
                deqd++;
            end
            checks++; if (reads - deqd > 2) begin errors++; $display("FAIL tog_credit cyc %0d got %0d exp <=2", cyc, reads - deqd); end
            if (cyc >= 80 && q.size() == 0 && w_ptr == r_ptr) break;
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL tog_drain got %0d exp 0", q.size()); end
    endtask

    task automatic test_rst_mid();
        @(negedge clk); deq_rdy = 1'b0;
        for (int k = 0; k < 4; k++) push(32'(32'h40 + k));
        #1;
        checks++; if (ren !== 1'b1) begin errors++; $display("FAIL rm_ren0 got %0h exp 1", ren); end
        @(negedge clk); #1;
        checks++; if (ren !== 1'b1) begin errors++; $display("FAIL rm_ren1 got %0h exp 1", ren); end
        @(negedge clk); #1;
        checks++; if (deq_val !== 1'b1) begin errors++; $display("FAIL rm_val_pre got %0h exp 1", deq_val); end
        checks++; if (ren !== 1'b0) begin errors++; $display("FAIL rm_ren2 got %0h exp 0", ren); end
        rst = 1'b1;
        @(posedge clk); #1; w_ptr = '0;
        @(negedge clk); rst = 1'b0; #1;
        checks++; if (deq_val !== 1'b0) begin errors++; $display("FAIL rm_val got %0h exp 0", deq_val); end
        checks++; if (r_ptr !== 3'd0) begin errors++; $display("FAIL rm_rptr got %0h exp 0", r_ptr); end
        checks++; if (ren !== 1'b0) begin errors++; $display("FAIL rm_ren got %0h exp 0", ren); end
        checks++; if (deq_msg !== 32'h0) begin errors++; $display("FAIL rm_msg got %0h exp 0", deq_msg); end
        deq_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++; if (deq_val !== 1'b0) begin errors++; $display("FAIL rm_late cyc %0d got %0h exp 0", i, deq_val); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_toggle();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
